// File: rtl/dvp_gen_pkg.sv
// Shared constants for the DVP frame generator: FSM codes, pattern modes,
// colour-bar table and LFSR definition.
package dvp_gen_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VPRE   = 3'd1;
  localparam state_t ST_VBLANK = 3'd2;
  localparam state_t ST_HFP    = 3'd3;
  localparam state_t ST_ACTIVE = 3'd4;
  localparam state_t ST_HBP    = 3'd5;
  localparam state_t ST_VTAIL  = 3'd6;

  typedef enum logic [1:0] {
    MODE_RAMP = 2'd0,
    MODE_BARS = 2'd1,
    MODE_CHK  = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][15:0] BAR_RGB565 = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  // x^16+x^14+x^13+x^11 in right-shifting Fibonacci form: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction

endpackage

// File: rtl/dvp_frame_gen_if.sv
// DVP camera-side bus: byte stream plus line/frame syncs.
interface dvp_frame_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] cam_half_pixel;
  logic                  cam_href;
  logic                  cam_vsync;

  modport master (output cam_half_pixel, cam_href, cam_vsync);
  modport slave  (input  cam_half_pixel, cam_href, cam_vsync);
endinterface

// File: rtl/dvp_pattern_src.sv
// Combinational test-pattern byte generator; the caller supplies all position state.
module dvp_pattern_src
  import dvp_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int CHK_SHIFT       = 3
) (
  input  mode_e                 mode_i,
  input  logic [15:0]           row_i,
  input  logic [31:0]           byte_idx_i,
  input  logic [15:0]           pix_x_i,
  input  logic [7:0]            pix_byte_i,
  input  logic [2:0]            bar_i,
  input  logic [15:0]           lfsr_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [15:0] pix;
  int          sh;

  always_comb begin
    if (mode_i == MODE_BARS)
      pix = BAR_RGB565[bar_i];
    else if ((((pix_x_i >> CHK_SHIFT) ^ (row_i >> CHK_SHIFT)) & 16'd1) != 16'd0)
      pix = 16'h0000;
    else
      pix = 16'hFFFF;
    // Pixel bytes go out MSB first.
    sh = DATA_WIDTH * (BYTES_PER_PIXEL - 1 - int'(pix_byte_i));
    case (mode_i)
      MODE_RAMP: data_o = DATA_WIDTH'(32'(row_i) + byte_idx_i);
      MODE_LFSR: data_o = DATA_WIDTH'(lfsr_i);
      default:   data_o = DATA_WIDTH'({16'h0000, pix} >> sh);
    endcase
  end
endmodule

// File: rtl/dvp_frame_gen.sv
// OV5640-style DVP source: frame/line timing FSM with registered outputs and
// a pluggable pattern generator fed with next-cycle position.
module dvp_frame_gen
  import dvp_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int VSYNC_PRE       = 10,
  parameter int VBLANK          = 20,
  parameter int HFP             = 20,
  parameter int HBP             = 20,
  parameter int VTAIL           = 50,
  parameter int CHK_SHIFT       = 3
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   start_i,
  input  logic                   continuous_i,
  input  logic [1:0]             mode_i,
  input  logic [15:0]            resolution_width_i,
  input  logic [15:0]            resolution_depth_i,
  dvp_frame_gen_if.master        cam,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [15:0]            frame_cnt_o
);
  state_t      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [15:0] w_q, w_d, h_q, h_d, row_q, row_d, x_q, x_d;
  logic [15:0] barpix_q, barpix_d, lfsr_q, lfsr_d, barw;
  logic [31:0] cnt_q, cnt_d, ph_len;
  logic [7:0]  pb_q, pb_d;
  logic [2:0]  bar_q, bar_d;
  logic        cfg_ok, ph_last, done_d;

  logic [DATA_WIDTH-1:0] pat, data_q;
  logic                  href_q, vsync_q, busy_q, done_q;
  logic [15:0]           fcnt_q;

  assign cfg_ok = (resolution_width_i != 16'd0) && (resolution_depth_i != 16'd0);
  assign barw   = w_q >> 3;

  always_comb begin
    case (state_q)
      ST_VPRE:   ph_len = 32'(VSYNC_PRE);
      ST_VBLANK: ph_len = 32'(VBLANK);
      ST_HFP:    ph_len = 32'(HFP);
      ST_ACTIVE: ph_len = 32'(w_q) * 32'(BYTES_PER_PIXEL);
      ST_HBP:    ph_len = 32'(HBP);
      ST_VTAIL:  ph_len = 32'(VTAIL);
      default:   ph_len = 32'd1;
    endcase
  end
  assign ph_last = (cnt_q == ph_len - 32'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    w_d      = w_q;
    h_d      = h_q;
    row_d    = row_q;
    x_d      = x_q;
    pb_d     = pb_q;
    bar_d    = bar_q;
    barpix_d = barpix_q;
    lfsr_d   = lfsr_q;

    if (state_q == ST_ACTIVE) begin
      lfsr_d = lfsr_next(lfsr_q);
      if (pb_q == 8'(BYTES_PER_PIXEL - 1)) begin
        pb_d = 8'd0;
        x_d  = x_q + 16'd1;
        // Bars advance every W>>3 pixels; leftover pixels remain in the last bar.
        if (bar_q != 3'd7 && barw != 16'd0 && barpix_q == barw - 16'd1) begin
          bar_d    = bar_q + 3'd1;
          barpix_d = 16'd0;
        end else begin
          barpix_d = barpix_q + 16'd1;
        end
      end else begin
        pb_d = pb_q + 8'd1;
      end
    end

    if (state_q == ST_IDLE) begin
      if (start_i && cfg_ok) begin
        state_d = ST_VPRE;
        cnt_d   = 32'd0;
        w_d     = resolution_width_i;
        h_d     = resolution_depth_i;
        mode_d  = mode_e'(mode_i);
      end
    end else if (!ph_last) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = 32'd0;
      case (state_q)
        ST_VPRE: begin
          state_d = ST_VBLANK;
          row_d   = 16'd0;
          lfsr_d  = LFSR_SEED;
        end
        ST_VBLANK: state_d = ST_HFP;
        ST_HFP: begin
          state_d  = ST_ACTIVE;
          x_d      = 16'd0;
          pb_d     = 8'd0;
          bar_d    = 3'd0;
          barpix_d = 16'd0;
        end
        ST_ACTIVE: state_d = ST_HBP;
        ST_HBP: begin
          if (row_q == h_q - 16'd1) begin
            state_d = ST_VTAIL;
          end else begin
            state_d = ST_HFP;
            row_d   = row_q + 16'd1;
          end
        end
        ST_VTAIL: begin
          if (continuous_i && cfg_ok) begin
            state_d = ST_VPRE;
            w_d     = resolution_width_i;
            h_d     = resolution_depth_i;
            mode_d  = mode_e'(mode_i);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign done_d = (state_d == ST_VTAIL) && (cnt_d == 32'(VTAIL - 1));

  // Fed with next-cycle position so the byte lands in the register alongside href.
  dvp_pattern_src #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
    .CHK_SHIFT      (CHK_SHIFT)
  ) u_pat (
    .mode_i    (mode_d),
    .row_i     (row_d),
    .byte_idx_i(cnt_d),
    .pix_x_i   (x_d),
    .pix_byte_i(pb_d),
    .bar_i     (bar_d),
    .lfsr_i    (lfsr_d),
    .data_o    (pat)
  );

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 32'd0;
      mode_q   <= MODE_RAMP;
      w_q      <= 16'd0;
      h_q      <= 16'd0;
      row_q    <= 16'd0;
      x_q      <= 16'd0;
      pb_q     <= 8'd0;
      bar_q    <= 3'd0;
      barpix_q <= 16'd0;
      lfsr_q   <= LFSR_SEED;
      data_q   <= '0;
      href_q   <= 1'b0;
      vsync_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fcnt_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      w_q      <= w_d;
      h_q      <= h_d;
      row_q    <= row_d;
      x_q      <= x_d;
      pb_q     <= pb_d;
      bar_q    <= bar_d;
      barpix_q <= barpix_d;
      lfsr_q   <= lfsr_d;
      data_q   <= (state_d == ST_ACTIVE) ? pat : '0;
      href_q   <= (state_d == ST_ACTIVE);
      vsync_q  <= (state_d == ST_IDLE) || (state_d == ST_VPRE) || (state_d == ST_VTAIL);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
      if (done_d) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign cam.cam_half_pixel = data_q;
  assign cam.cam_href       = href_q;
  assign cam.cam_vsync      = vsync_q;
  assign busy_o             = busy_q;
  assign frame_done_o       = done_q;
  assign frame_cnt_o        = fcnt_q;
endmodule

// File: tb/tb_dvp_frame_gen.sv
// Bench for dvp_frame_gen: table of frame configs plus hand-written reset,
// zero-size and continuous sequences, checked against a positional frame model.
module tb_dvp_frame_gen;
  logic        clk = 1'b0;
  logic        resetn, start, cont;
  logic [1:0]  mode;
  logic [15:0] wid, dep;
  logic        busy, done;
  logic [15:0] fcnt;

  always #5 clk = ~clk;

  dvp_frame_gen_if #(.DATA_WIDTH(8)) cam ();

  dvp_frame_gen dut (
    .clk_i             (clk),
    .resetn_i          (resetn),
    .start_i           (start),
    .continuous_i      (cont),
    .mode_i            (mode),
    .resolution_width_i(wid),
    .resolution_depth_i(dep),
    .cam               (cam),
    .busy_o            (busy),
    .frame_done_o      (done),
    .frame_cnt_o       (fcnt)
  );

  int n_chk = 0, n_fail = 0, exp_cnt = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct {
    int w; int h; int md; int poke_t; int poke; int exp_len;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (fb << 15);
  endfunction

  function automatic logic [7:0] exp_byte(input int md, input int w, input int row,
                                          input int j, input logic [15:0] lf);
    int x, b, bar;
    logic [15:0] pix;
    x = j / 2; b = j % 2; pix = 16'h0000;
    case (md)
      0: return 8'((row + j) % 256);
      3: return lf[7:0];
      1: begin
        bar = (w < 8) ? 0 : x / (w / 8);
        if (bar > 7) bar = 7;
        pix = bars[bar];
      end
      default: pix = (((x / 8) + (row / 8)) % 2 == 1) ? 16'h0000 : 16'hFFFF;
    endcase
    return (b == 0) ? pix[15:8] : pix[7:0];
  endfunction

  // Caller sits on a falling edge; with launch=0 that edge is already cycle 1 of the frame.
  task automatic run_frame(input int w, input int h, input int md, input bit launch,
                           input bit cont_after, input int poke_t, input int poke,
                           input int exp_len, input string tag);
    int L = 40 + 2 * w;
    int total = 30 + h * L + 50;
    int s_err = 0, d_err = 0, done_t = -1, n_done = 0;
    int start_cnt = exp_cnt;
    int u, r, p;
    logic [15:0] lf = 16'hACE1;
    bit evs, ehr;
    logic [7:0] ed;
    if (launch) begin
      wid = 16'(w); dep = 16'(h); mode = 2'(md);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 1; t <= total; t++) begin
      if (t == poke_t) begin
        case (poke)
          1: start = 1'b1;
          2: mode = mode ^ 2'd1;
          3: wid = wid + 16'd3;
          4: cont = 1'b0;
          default: ;
        endcase
      end
      if (poke == 1 && t == poke_t + 1) start = 1'b0;
      evs = (t <= 10) || (t > 30 + h * L);
      ehr = 1'b0; ed = 8'h00;
      if (t > 30 && t <= 30 + h * L) begin
        u = t - 31; r = u / L; p = u % L;
        if (p >= 20 && p < 20 + 2 * w) begin
          ehr = 1'b1;
          ed = exp_byte(md, w, r, p - 20, lf);
          lf = lfsr_step(lf);
        end
      end
      if (cam.cam_vsync !== evs || cam.cam_href !== ehr || busy !== 1'b1 ||
          fcnt !== 16'(start_cnt + int'(t == total))) begin
        if (s_err == 0)
          $display("  %s: first timing difference at cycle %0d (vs=%b/%b hr=%b/%b busy=%b cnt=%0d)",
                   tag, t, cam.cam_vsync, evs, cam.cam_href, ehr, busy, fcnt);
        s_err++;
      end
      if (cam.cam_half_pixel !== ed) begin
        if (d_err == 0)
          $display("  %s: first data difference at cycle %0d (got %0h want %0h)",
                   tag, t, cam.cam_half_pixel, ed);
        d_err++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_t < 0) done_t = t;
      end
      @(negedge clk);
    end
    exp_cnt = (exp_cnt + 1) % 65536;
    check({tag, " timing_errs"}, 64'(s_err), 64'd0);
    check({tag, " data_errs"}, 64'(d_err), 64'd0);
    check({tag, " done_cycle"}, 64'(done_t), 64'((exp_len != 0) ? exp_len : total));
    check({tag, " done_pulses"}, 64'(n_done), 64'd1);
    check({tag, " busy_after"}, 64'(busy), 64'(cont_after));
    check({tag, " frame_cnt"}, 64'(fcnt), 64'(exp_cnt));
  endtask

  initial begin
    int n_busy;
    vecs[0] = '{4, 2, 0, 0, 0, 176};    // ramp, reference frame
    vecs[1] = '{16, 1, 1, 0, 0, 152};   // colour bars, two pixels per bar
    vecs[2] = '{16, 16, 2, 0, 0, 1232}; // checkerboard
    vecs[3] = '{4, 2, 3, 0, 0, 176};    // LFSR
    vecs[4] = '{4, 2, 0, 53, 1, 176};   // start pulse during ACTIVE
    vecs[5] = '{8, 2, 1, 40, 2, 192};   // mode changed mid-frame
    vecs[6] = '{3, 2, 1, 0, 0, 172};    // narrower than 8 -> bar 0 only
    vecs[7] = '{20, 2, 1, 0, 0, 240};   // remainder pixels in last bar
    vecs[8] = '{6, 3, 2, 60, 3, 236};   // width changed mid-frame
    vecs[9] = '{12, 2, 3, 55, 2, 208};  // LFSR, mode flipped mid-frame

    resetn = 1'b0; start = 1'b0; cont = 1'b0; mode = 2'd0; wid = 16'd4; dep = 16'd2;
    repeat (3) @(negedge clk);
    check("rst vsync", 64'(cam.cam_vsync), 64'd1);
    check("rst href", 64'(cam.cam_href), 64'd0);
    check("rst data", 64'(cam.cam_half_pixel), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst frame_cnt", 64'(fcnt), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    n_busy = 0;
    wid = 16'd0; dep = 16'd2; start = 1'b1;
    repeat (4) begin @(negedge clk); n_busy += int'(busy); end
    wid = 16'd4; dep = 16'd0;
    repeat (4) begin @(negedge clk); n_busy += int'(busy); end
    start = 1'b0;
    check("zero_dim busy_cycles", 64'(n_busy), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].w, vecs[i].h, vecs[i].md, 1'b1, 1'b0, vecs[i].poke_t,
                vecs[i].poke, vecs[i].exp_len, $sformatf("vec%0d", i));

    // Reset while driving row 1, byte 3 of a 4x2 ramp frame.
    wid = 16'd4; dep = 16'd2; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (101) @(negedge clk);
    check("pre_rst href", 64'(cam.cam_href), 64'd1);
    check("pre_rst data", 64'(cam.cam_half_pixel), 64'd4);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst vsync", 64'(cam.cam_vsync), 64'd1);
    check("mid_rst href", 64'(cam.cam_href), 64'd0);
    check("mid_rst data", 64'(cam.cam_half_pixel), 64'd0);
    check("mid_rst busy", 64'(busy), 64'd0);
    check("mid_rst frame_cnt", 64'(fcnt), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_frame(4, 2, 0, 1'b1, 1'b0, 0, 0, 176, "post_rst");

    // Back-to-back frames, continuous dropped during the second one.
    cont = 1'b1;
    run_frame(4, 2, 0, 1'b1, 1'b1, 0, 0, 176, "cont1");
    run_frame(4, 2, 0, 1'b0, 1'b0, 20, 4, 176, "cont2");
    check("cont frame_cnt", 64'(fcnt), 64'd3);

    for (int k = 0; k < 4; k++)
      run_frame(int'($urandom_range(1, 24)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), 1'b1, 1'b0, 0, 0, 0, $sformatf("rnd%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
